apb_spi_flash_ctrl: RTL

APB_SPI_FLASH_CTRL -- requirements
Module: apb_spi_flash_ctrl

---
 rtl/apb_spi_flash_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/apb_spi_flash_ctrl.sv
// APB slave driving a mode-0 SPI flash one byte at a time.
// Ports: pclk/preset (sync, active-high), APB psel/penable/pwrite/paddr/pwdata/pready/prdata/pslverr, flash cs_n/sck/mosi/miso.
module apb_spi_flash_ctrl #(
    parameter logic [15:0] CLKDIV_RESET = 16'h0001
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [7:0]  paddr,
    input  logic [31:0] pwdata,
    output logic        pready,
    output logic [31:0] prdata,
    output logic        pslverr,
    output logic        flash_cs_n,
    output logic        flash_sck,
    output logic        flash_mosi,
    input  logic        flash_miso
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]  state;
    logic [15:0] clk_div;
    logic        cs_n;
    logic [7:0]  rx_data;
    logic        busy;
    logic        rx_valid;
    logic [7:0]  tx_shift;
    logic [7:0]  rx_shift;
    logic [15:0] hcnt;
    logic [4:0]  ecnt;
    logic        sck;

    logic [5:0] word;
    logic       access;
    logic       addr_bad;
    logic       busy_err;
    logic       wr_ok;
    logic       rd_data;
    logic       unused_bits;

    assign word     = paddr[7:2];
    assign access   = psel & penable;
    assign addr_bad = (word > 6'd3);
    // DATA and CS_N are locked while a byte is on the wire
    assign busy_err = pwrite & busy & ((word == 6'd1) | (word == 6'd2));
    assign wr_ok    = access & pwrite & ~addr_bad & ~busy_err;
    assign rd_data  = access & ~pwrite & (word == 6'd1);

    assign pready     = access;
    assign pslverr    = access & (addr_bad | busy_err);
    assign flash_cs_n = cs_n;
    assign flash_sck  = sck;
    assign flash_mosi = (state == ST_SHIFT) & tx_shift[7];

    assign unused_bits = ^{pwdata[31:16], paddr[1:0]};

    always_comb begin
        prdata = 32'd0;
        if (access & ~addr_bad) begin
            case (word)
                6'd0:    prdata = {16'd0, clk_div};
                6'd1:    prdata = {24'd0, rx_data};
                6'd2:    prdata = {31'd0, cs_n};
                6'd3:    prdata = {30'd0, rx_valid, busy};
                default: prdata = 32'd0;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state    <= ST_IDLE;
            clk_div  <= CLKDIV_RESET;
            cs_n     <= 1'b1;
            rx_data  <= 8'h00;
            busy     <= 1'b0;
            rx_valid <= 1'b0;
            tx_shift <= 8'h00;
            rx_shift <= 8'h00;
            hcnt     <= 16'd0;
            ecnt     <= 5'd0;
            sck      <= 1'b0;
        end else begin
            if (wr_ok && word == 6'd0)
                clk_div <= pwdata[15:0];
            if (wr_ok && word == 6'd2)
                cs_n <= pwdata[0];
            // set in DONE wins over clear-on-read
            if (rd_data)
                rx_valid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (wr_ok && word == 6'd1) begin
                        state    <= ST_SHIFT;
                        busy     <= 1'b1;
                        tx_shift <= pwdata[7:0];
                        hcnt     <= clk_div;
                        ecnt     <= 5'd0;
                        sck      <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (hcnt == 16'd0) begin
                        sck  <= ~sck;
                        hcnt <= clk_div;
                        ecnt <= ecnt + 5'd1;
                        if (!sck)
                            rx_shift <= {rx_shift[6:0], flash_miso};
                        else
                            tx_shift <= {tx_shift[6:0], 1'b0};
                        if (ecnt == 5'd15)
                            state <= ST_DONE;
                    end else begin
                        hcnt <= hcnt - 16'd1;
                    end
                end
                ST_DONE: begin
                    rx_data  <= rx_shift;
                    busy     <= 1'b0;
                    rx_valid <= 1'b1;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
